// File: rtl/timer_cmp_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : timer_cmp_sequencer
// Purpose  : Owns the 64-bit mtime/mtimecmp timer bus port and programs
//            mtimecmp for software. It supports one-shot and drift-free
//            periodic ticks. It also arbitrates the timer's single slave port
//            between the sequencer and a host (core data) port.
// Ports    : ck_i/rst_i        clock, synchronous active-high reset
//            start_i/stop_i    arm request pulse / abort and disarm
//            periodic_i        mode captured at start (1 = periodic)
//            period_i          tick period in mtime counts, captured at start
//            busy_o            sequencer not idle
//            done_o            pulse after each mtimecmp programming pass
//            tick_o            pulse per timer expiry seen while armed
//            seq_err_o         sticky timer error seen on a sequencer access
//            host_*            host request in / response out (same cycle)
//            timer_*           timer bus out / response in (same cycle)
//            timer_intr_i      timer interrupt level
// Revision : 1.0 - initial release
// ============================================================================
module timer_cmp_sequencer #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] TIMER_BASE    = '0
) (
    input  logic                     ck_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     stop_i,
    input  logic                     periodic_i,
    input  logic [31:0]              period_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     tick_o,
    output logic                     seq_err_o,
    input  logic                     host_req_i,
    input  logic [ADDRESS_WIDTH-1:0] host_addr_i,
    input  logic                     host_we_i,
    input  logic [3:0]               host_be_i,
    input  logic [DATA_WIDTH-1:0]    host_wdata_i,
    output logic                     host_gnt_o,
    output logic                     host_rvalid_o,
    output logic [DATA_WIDTH-1:0]    host_rdata_o,
    output logic                     host_err_o,
    output logic                     timer_req_o,
    output logic [ADDRESS_WIDTH-1:0] timer_addr_o,
    output logic                     timer_we_o,
    output logic [3:0]               timer_be_o,
    output logic [DATA_WIDTH-1:0]    timer_wdata_o,
    input  logic                     timer_rvalid_i,
    input  logic [DATA_WIDTH-1:0]    timer_rdata_i,
    input  logic                     timer_err_i,
    input  logic                     timer_intr_i
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_RD_HI1  = 3'd1;
    localparam logic [2:0] c_RD_LO   = 3'd2;
    localparam logic [2:0] c_RD_HI2  = 3'd3;
    localparam logic [2:0] c_WR_HMAX = 3'd4;
    localparam logic [2:0] c_WR_LO   = 3'd5;
    localparam logic [2:0] c_WR_HI   = 3'd6;
    localparam logic [2:0] c_ARMED   = 3'd7;

    localparam logic [ADDRESS_WIDTH-1:0] c_OFF_MTIME_LO = ADDRESS_WIDTH'(4'h0);
    localparam logic [ADDRESS_WIDTH-1:0] c_OFF_MTIME_HI = ADDRESS_WIDTH'(4'h4);
    localparam logic [ADDRESS_WIDTH-1:0] c_OFF_CMP_LO   = ADDRESS_WIDTH'(4'h8);
    localparam logic [ADDRESS_WIDTH-1:0] c_OFF_CMP_HI   = ADDRESS_WIDTH'(4'hC);

    logic [2:0]                r_state;
    logic [2:0]                w_next;
    logic [DATA_WIDTH-1:0]     r_hi;
    logic [DATA_WIDTH-1:0]     r_lo;
    logic [2*DATA_WIDTH-1:0]   r_target;
    logic [31:0]               r_period;
    logic                      r_periodic;
    logic                      r_seq_err;
    logic                      r_done;
    logic                      r_tick;

    logic                      w_bus_own;
    logic [ADDRESS_WIDTH-1:0]  w_off;
    logic                      w_seq_we;
    logic [DATA_WIDTH-1:0]     w_seq_wdata;
    logic                      w_seq_err;
    logic                      w_host_gnt;
    logic                      w_start;
    logic [2*DATA_WIDTH-1:0]   w_period_ext;
    logic [2*DATA_WIDTH-1:0]   w_target_init;
    logic [2*DATA_WIDTH-1:0]   w_target_rearm;

    assign w_period_ext   = {{(2*DATA_WIDTH-32){1'b0}}, r_period};
    assign w_target_init  = {r_hi, r_lo} + w_period_ext;
    // Re-arm adds to the previous target rather than re-reading mtime, so
    // service latency never accumulates into the tick phase.
    assign w_target_rearm = r_target + w_period_ext;

    assign w_start    = (r_state == c_IDLE) && start_i && !stop_i;
    assign w_seq_err  = w_bus_own && timer_err_i;
    assign w_host_gnt = host_req_i && !w_bus_own;

    always_comb begin
        w_next      = r_state;
        w_bus_own   = 1'b0;
        w_off       = c_OFF_MTIME_LO;
        w_seq_we    = 1'b0;
        w_seq_wdata = '0;
        case (r_state)
            c_IDLE: begin
                if (start_i) w_next = c_RD_HI1;
            end
            c_RD_HI1: begin
                w_bus_own = 1'b1;
                w_off     = c_OFF_MTIME_HI;
                w_next    = c_RD_LO;
            end
            c_RD_LO: begin
                w_bus_own = 1'b1;
                w_off     = c_OFF_MTIME_LO;
                w_next    = c_RD_HI2;
            end
            c_RD_HI2: begin
                w_bus_own = 1'b1;
                w_off     = c_OFF_MTIME_HI;
                // A changed high word means the low word carried in between;
                // re-read the low word against the new high word.
                w_next    = (timer_rdata_i != r_hi) ? c_RD_LO : c_WR_HMAX;
            end
            c_WR_HMAX: begin
                // Park the compare high word at all-ones so the half-written
                // value in the next cycle cannot fire a spurious interrupt.
                w_bus_own   = 1'b1;
                w_off       = c_OFF_CMP_HI;
                w_seq_we    = 1'b1;
                w_seq_wdata = '1;
                w_next      = c_WR_LO;
            end
            c_WR_LO: begin
                w_bus_own   = 1'b1;
                w_off       = c_OFF_CMP_LO;
                w_seq_we    = 1'b1;
                w_seq_wdata = r_target[DATA_WIDTH-1:0];
                w_next      = c_WR_HI;
            end
            c_WR_HI: begin
                w_bus_own   = 1'b1;
                w_off       = c_OFF_CMP_HI;
                w_seq_we    = 1'b1;
                w_seq_wdata = r_target[2*DATA_WIDTH-1:DATA_WIDTH];
                w_next      = (r_periodic && (r_period != 32'h0)) ? c_ARMED : c_IDLE;
            end
            c_ARMED: begin
                if (timer_intr_i) w_next = c_WR_HMAX;
            end
            default: w_next = c_IDLE;
        endcase
        if (w_seq_err) w_next = c_IDLE;
        if (stop_i)    w_next = c_IDLE;
    end

    always_ff @(posedge ck_i) begin
        if (rst_i) begin
            r_state    <= c_IDLE;
            r_hi       <= '0;
            r_lo       <= '0;
            r_target   <= '0;
            r_period   <= '0;
            r_periodic <= 1'b0;
            r_seq_err  <= 1'b0;
            r_done     <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == c_WR_HI) && !stop_i && !timer_err_i;
            r_tick  <= (r_state == c_ARMED) && timer_intr_i && !stop_i;
            if (w_start) begin
                r_period   <= period_i;
                r_periodic <= periodic_i;
                r_seq_err  <= 1'b0;
            end
            if (w_seq_err) r_seq_err <= 1'b1;
            case (r_state)
                c_RD_HI1: r_hi <= timer_rdata_i;
                c_RD_LO:  r_lo <= timer_rdata_i;
                c_RD_HI2: begin
                    if (timer_rdata_i != r_hi) r_hi     <= timer_rdata_i;
                    else                       r_target <= w_target_init;
                end
                c_ARMED: begin
                    if (timer_intr_i) r_target <= w_target_rearm;
                end
                default: ;
            endcase
        end
    end

    assign busy_o    = (r_state != c_IDLE);
    assign done_o    = r_done;
    assign tick_o    = r_tick;
    assign seq_err_o = r_seq_err;

    assign timer_req_o   = w_bus_own || w_host_gnt;
    assign timer_addr_o  = w_bus_own ? (TIMER_BASE + w_off) : (w_host_gnt ? host_addr_i : '0);
    assign timer_we_o    = w_bus_own ? w_seq_we : (w_host_gnt && host_we_i);
    assign timer_be_o    = w_bus_own ? 4'hF : (w_host_gnt ? host_be_i : 4'h0);
    assign timer_wdata_o = w_bus_own ? w_seq_wdata : (w_host_gnt ? host_wdata_i : '0);

    assign host_gnt_o    = w_host_gnt;
    assign host_rvalid_o = w_host_gnt && timer_rvalid_i;
    assign host_rdata_o  = w_host_gnt ? timer_rdata_i : '0;
    assign host_err_o    = w_host_gnt && timer_err_i;

endmodule
`default_nettype wire
